div_seq_32: RTL and testbench

DIV_SEQ_32 -- requirements
Module: div_seq_32

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 34 +++
 rtl/div_seq_32.sv | 114 +++++++++++
 tb/tb_div_seq_32.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Holds the FSM state encoding and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of an unsigned divider (combinational).
// Ports:
//   rem_in   - partial remainder, always < divisor
//   quo_in   - quotient/dividend shift register; its MSB is the next dividend bit
//   divisor  - latched divisor
//   rem_out  - next partial remainder
//   quo_out  - shift register with the new quotient bit appended at the LSB
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // The shifted remainder needs WIDTH+1 bits: with a full-scale divisor the
    // partial remainder can be up to 2^WIDTH-2, and shifting it in would
    // otherwise drop the top bit.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        rem_sh  = {rem_in, quo_in[WIDTH-1]};
        diff    = rem_sh - {1'b0, divisor};
        fits    = (rem_sh >= {1'b0, divisor});
        // Result of a successful subtract is < divisor, so it fits WIDTH bits.
        rem_out = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_seq_32.sv
// Sequential unsigned divider, one quotient bit per clock (restoring).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - begin a division (accepted in IDLE or DONE, ignored in RUN)
//   dividend     - unsigned dividend
//   divisor      - unsigned divisor
//   busy         - high while iterating
//   done         - one-cycle pulse when quotient/remainder are valid
//   quotient     - unsigned quotient (all ones on divide by zero)
//   remainder    - unsigned remainder (dividend on divide by zero)
//   div_by_zero  - last completed division had a zero divisor
module div_seq_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;    // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             accept;
    logic             last;
    logic             dvs_zero;

    assign accept   = start && (state != S_RUN);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign dvs_zero = (divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = dvs_zero ? S_DONE : S_RUN;
            S_RUN:  if (last)  next_state = S_DONE;
            S_DONE: begin
                if (start) next_state = dvs_zero ? S_DONE : S_RUN;
                else       next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Datapath: operands, iteration, and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            // Zero divisor skips RUN, so results are posted at acceptance.
            if (dvs_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == S_RUN) begin
            cnt   <= cnt + 1'b1;
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (last) begin
                quotient    <= quo_nx;
                remainder   <= rem_nx;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_seq_32.sv
// Directed bench for div_seq_32. Inputs change and outputs are sampled on the
// falling edge; latency 1 means done is seen right after the accepting edge.
module tb_div_seq_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    div_seq_32 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a falling edge; start is seen by the next rising edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
    endtask

    // Counts falling edges after acceptance until done, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int seen;

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quo", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);

        // 100 / 7
        launch(100, 7);
        chk("a_busy", busy, 1);
        wait_done(lat);
        chk("a_lat", lat, 33);
        chk("a_quo", quotient, 14);
        chk("a_rem", remainder, 2);
        chk("a_dbz", div_by_zero, 0);
        chk("a_busy_done", busy, 0);
        @(negedge clk);
        chk("a_done_pulse", done, 0);

        // full-scale dividend
        launch(32'hFFFF_FFFF, 1);
        wait_done(lat);
        chk("b_lat", lat, 33);
        chk("b_quo", quotient, 32'hFFFF_FFFF);
        chk("b_rem", remainder, 0);
        @(negedge clk);

        // full-scale divisor
        launch(5, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("c_quo", quotient, 0);
        chk("c_rem", remainder, 5);
        @(negedge clk);

        // divide by zero
        launch(123, 0);
        chk("z_busy", busy, 0);
        wait_done(lat);
        chk("z_lat", lat, 1);
        chk("z_quo", quotient, 32'hFFFF_FFFF);
        chk("z_rem", remainder, 123);
        chk("z_dbz", div_by_zero, 1);
        @(negedge clk);
        chk("z_busy2", busy, 0);
        chk("z_done_pulse", done, 0);
        chk("z_hold_rem", remainder, 123);

        // start during RUN is ignored; also clears div_by_zero
        launch(1000, 7);
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 10) begin
                start = 1'b1; dividend = 77; divisor = 3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("i_lat", lat, 33);
        chk("i_quo", quotient, 142);
        chk("i_rem", remainder, 6);
        chk("i_dbz", div_by_zero, 0);
        @(negedge clk);
        chk("i_idle", busy, 0);

        // reset in the middle of RUN
        launch(1000, 7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        chk("r_quo", quotient, 0);
        chk("r_rem", remainder, 0);
        chk("r_dbz", div_by_zero, 0);
        seen = 0;
        repeat (40) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        chk("r_no_done", seen, 0);
        launch(100, 7);
        wait_done(lat);
        chk("r2_lat", lat, 33);
        chk("r2_quo", quotient, 14);
        chk("r2_rem", remainder, 2);

        // back-to-back: start held in the DONE cycle
        @(negedge clk);
        launch(64, 8);
        wait_done(lat);
        chk("bb1_quo", quotient, 8);
        chk("bb1_done", done, 1);
        launch(50, 5);
        chk("bb2_busy", busy, 1);
        chk("bb2_hold_quo", quotient, 8);
        wait_done(lat);
        chk("bb2_lat", lat, 33);
        chk("bb2_quo", quotient, 10);
        chk("bb2_rem", remainder, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
